// File: rtl/dffsr_test_pkg.sv
// -----------------------------------------------------------------------------
// dffsr_test_pkg
// Shared types, constants and helper functions for the set/reset flip-flop
// self-test stage.
//   state_e      : checker FSM states
//   vec_t        : one stimulus vector {reset, set, data}
//   DIRECTED     : eight hand-picked vectors issued before any LFSR vector
//   LFSR_TAPS    : Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1
//   exp_q_of     : golden flip-flop model (reset dominates set)
//   safe_seed    : maps the forbidden all-zero LFSR seed to 8'h01
//   lfsr_step    : one Galois LFSR advance
//   lfsr_to_vec  : LFSR state to stimulus vector mapping
// -----------------------------------------------------------------------------
package dffsr_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic reset;
    logic set;
    logic data;
  } vec_t;

  localparam int unsigned NUM_DIRECTED = 8;

  // Vector parked on the flip-flop whenever no run is in progress.
  localparam vec_t IDLE_VEC = vec_t'(3'b100);

  // Expected q for these vectors: 0, 1, 0, 1, 0, 1, 0, 1.
  // Vector 6 drives reset and set together to expose set-over-reset bugs.
  localparam vec_t DIRECTED [NUM_DIRECTED] = '{
    vec_t'(3'b100), vec_t'(3'b001), vec_t'(3'b000), vec_t'(3'b010),
    vec_t'(3'b000), vec_t'(3'b011), vec_t'(3'b110), vec_t'(3'b001)
  };

  // Taps 8,6,5,4 in right-shifting Galois form land on bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic exp_q_of(input vec_t v);
    if (v.reset)    return 1'b0;
    else if (v.set) return 1'b1;
    else            return v.data;
  endfunction

  function automatic logic [7:0] safe_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
  endfunction

  // set and reset are each the AND of two bits so they fire on roughly a
  // quarter of the vectors, leaving data visible most of the time.
  function automatic vec_t lfsr_to_vec(input logic [7:0] l);
    vec_t v;
    v.data  = l[0];
    v.set   = l[1] & l[3];
    v.reset = l[2] & l[4];
    return v;
  endfunction

endpackage

// File: rtl/dffsr_vec_lfsr.sv
// -----------------------------------------------------------------------------
// dffsr_vec_lfsr
// 8-bit Galois LFSR that supplies pseudo-random stimulus vectors.
//   clk       in  system clock
//   reset_n   in  synchronous active-low reset (loads the seed)
//   load_i    in  reload the seed (has priority over advance_i)
//   advance_i in  step the LFSR once
//   vec_o     out vector derived from the current LFSR state
// -----------------------------------------------------------------------------
module dffsr_vec_lfsr
  import dffsr_test_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic advance_i,
  output vec_t vec_o
);

  localparam logic [7:0] SEED_NZ = safe_seed(SEED);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED_NZ;
    end else if (advance_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= SEED_NZ;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign vec_o = lfsr_to_vec(lfsr_q);

endmodule

// File: rtl/dffsr_stim_checker.sv
// -----------------------------------------------------------------------------
// dffsr_stim_checker
// Self-test stage for a set/reset D flip-flop clocked by the same clk.
// Issues NUM_VECTORS vectors (directed table first, then LFSR), and checks the
// flip-flop outputs one cycle after each vector is captured.
//   clk         in   system clock, also clocks the flip-flop under test
//   reset_n     in   synchronous active-low reset
//   start       in   one-cycle pulse, starts a run from IDLE or DONE
//   dut_q       in   flip-flop q
//   dut_notq    in   flip-flop notq
//   stim_set    out  flip-flop set (active-high)
//   stim_data   out  flip-flop data
//   stim_reset  out  flip-flop reset (active-high)
//   busy        out  run or drain in progress
//   done        out  results valid
//   pass        out  done with zero mismatches
//   err_count   out  mismatching vectors, saturating at 255
//   first_fail  out  index of the first mismatching vector, 8'hFF if none
// -----------------------------------------------------------------------------
module dffsr_stim_checker
  import dffsr_test_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 16,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       dut_q,
  input  logic       dut_notq,
  output logic       stim_set,
  output logic       stim_data,
  output logic       stim_reset,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_fail
);

  localparam logic [7:0] LAST_IDX  = 8'(NUM_VECTORS - 1);
  localparam logic [7:0] TABLE_LEN = 8'(NUM_DIRECTED);
  localparam logic [7:0] NO_FAIL   = 8'hFF;

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  vec_t       stim_q, stim_d;

  // Check stage: describes the vector the flip-flop captured at the last edge.
  logic       chk_valid_q, chk_valid_d;
  logic       chk_exp_q, chk_exp_d;
  logic [7:0] chk_idx_q, chk_idx_d;

  logic [7:0] err_q, err_d;
  logic [7:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;

  logic       lfsr_load;
  logic       lfsr_adv;
  vec_t       lfsr_vec;
  logic       mismatch;
  logic [7:0] nxt_idx;

  dffsr_vec_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (lfsr_load),
    .advance_i (lfsr_adv),
    .vec_o     (lfsr_vec)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stim_d       = stim_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    lfsr_load    = 1'b0;
    lfsr_adv     = 1'b0;
    nxt_idx      = idx_q + 8'd1;

    // The vector on stim_q this cycle is captured by the flip-flop at the
    // coming edge; its expectation moves into the check stage at that edge
    // and is compared one edge later.
    chk_valid_d = (state_q == ST_RUN);
    chk_exp_d   = exp_q_of(stim_q);
    chk_idx_d   = idx_q;

    mismatch = chk_valid_q && ((dut_q != chk_exp_q) || (dut_notq != ~chk_exp_q));
    if (mismatch) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
      if (first_fail_q == NO_FAIL) begin
        first_fail_d = chk_idx_q;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          idx_d        = 8'd0;
          stim_d       = DIRECTED[0];
          err_d        = 8'd0;
          first_fail_d = NO_FAIL;
          lfsr_load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
          stim_d  = IDLE_VEC;
        end else begin
          idx_d = nxt_idx;
          if (nxt_idx < TABLE_LEN) begin
            stim_d = DIRECTED[nxt_idx[2:0]];
          end else begin
            // Vector uses the current LFSR state, then the LFSR steps on.
            stim_d   = lfsr_vec;
            lfsr_adv = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        stim_d  = IDLE_VEC;
      end
    endcase

    // Uses next-state values so pass is valid in the first DONE cycle,
    // including the final check that completes on the DRAIN edge.
    pass_d = (state_d == ST_DONE) && (err_d == 8'd0);
  end

  // NOTE: reset is synchronous: it is only seen at a rising clk edge, so a
  // low pulse must straddle an edge to abort a run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'd0;
      stim_q       <= IDLE_VEC;
      chk_valid_q  <= 1'b0;
      chk_exp_q    <= 1'b0;
      chk_idx_q    <= 8'd0;
      err_q        <= 8'd0;
      first_fail_q <= NO_FAIL;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stim_q       <= stim_d;
      chk_valid_q  <= chk_valid_d;
      chk_exp_q    <= chk_exp_d;
      chk_idx_q    <= chk_idx_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  assign stim_reset = stim_q.reset;
  assign stim_set   = stim_q.set;
  assign stim_data  = stim_q.data;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_dffsr_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_dffsr_stim_checker
// Two checker instances (16 and 3 vectors) driving behavioural flip-flop
// models; instance a's model can be switched into several faulty variants.
// -----------------------------------------------------------------------------
module tb_dffsr_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_a, start_b;
  int   fault_mode;  // 0 good, 1 q stuck at 1, 2 notq tied to q, 3 set over reset

  logic       dut_q_a, dut_notq_a, stim_set_a, stim_data_a, stim_reset_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a, ff_a;
  logic       dut_q_b, dut_notq_b, stim_set_b, stim_data_b, stim_reset_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] err_b, ff_b;

  dffsr_stim_checker #(.NUM_VECTORS(16), .LFSR_SEED(8'hA5)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .dut_q(dut_q_a), .dut_notq(dut_notq_a),
    .stim_set(stim_set_a), .stim_data(stim_data_a), .stim_reset(stim_reset_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a)
  );

  dffsr_stim_checker #(.NUM_VECTORS(3), .LFSR_SEED(8'hA5)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .dut_q(dut_q_b), .dut_notq(dut_notq_b),
    .stim_set(stim_set_b), .stim_data(stim_data_b), .stim_reset(stim_reset_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b)
  );

  // Behavioural flip-flops under test.
  logic q_a = 1'b0;
  logic q_b = 1'b0;
  always @(posedge clk) begin
    if (fault_mode == 3) q_a <= stim_set_a ? 1'b1 : (stim_reset_a ? 1'b0 : stim_data_a);
    else                 q_a <= stim_reset_a ? 1'b0 : (stim_set_a ? 1'b1 : stim_data_a);
    q_b <= stim_reset_b ? 1'b0 : (stim_set_b ? 1'b1 : stim_data_b);
  end
  assign dut_q_a    = (fault_mode == 1) ? 1'b1 : q_a;
  assign dut_notq_a = (fault_mode == 2) ? dut_q_a : ~dut_q_a;
  assign dut_q_b    = q_b;
  assign dut_notq_b = ~q_b;

  // Hand-derived {reset,set,data}: table, then LFSR states
  // A5, EA, 75, 82, 41, 98, 4C, 26.
  logic [2:0] exp_vec [16] = '{
    3'b100, 3'b001, 3'b000, 3'b010, 3'b000, 3'b011, 3'b110, 3'b001,
    3'b001, 3'b010, 3'b101, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000
  };
  logic [2:0] log_v [16];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge of run cycle 0.
  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Counts busy cycles (bounded), logs issued vectors, and optionally pulses
  // start at run cycle extra_at. Ends at the first falling edge after busy.
  task automatic wait_idle(input bit sel, input int extra_at, output int cycles);
    cycles = 0;
    while ((sel ? busy_b : busy_a) && cycles < 200) begin
      if (cycles < 16)
        log_v[cycles] = sel ? {stim_reset_b, stim_set_b, stim_data_b}
                            : {stim_reset_a, stim_set_a, stim_data_a};
      if (sel) start_b = (cycles == extra_at);
      else     start_a = (cycles == extra_at);
      cycles++;
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_results_a(input string tag, input logic p,
                                 input logic [7:0] e, input logic [7:0] f);
    check({tag, "_done"}, done_a, 1'b1);
    check({tag, "_pass"}, pass_a, p);
    check({tag, "_err"},  err_a,  e);
    check({tag, "_ff"},   ff_a,   f);
  endtask

  int cyc;

  initial begin
    reset_n    = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    fault_mode = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_err", err_a, 8'h00);
    check("rst_ff", ff_a, 8'hFF);
    check("rst_stim", {stim_reset_a, stim_set_a, stim_data_a}, 3'b100);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_hold", busy_a, 1'b0);

    // Good flip-flop, full 16-vector run.
    pulse_start(1'b0);
    wait_idle(1'b0, -1, cyc);
    check("good_busy_cycles", cyc, 17);
    check_results_a("good", 1'b1, 8'd0, 8'hFF);
    for (int k = 0; k < 16; k++)
      check($sformatf("vec%0d", k), log_v[k], exp_vec[k]);
    check("done_stim_idle", {stim_reset_a, stim_set_a, stim_data_a}, 3'b100);

    // q stuck at 1: nine vectors expect 0 (four table, five LFSR).
    fault_mode = 1;
    pulse_start(1'b0);
    wait_idle(1'b0, -1, cyc);
    check_results_a("stuck1", 1'b0, 8'd9, 8'd0);

    // Restart from DONE clears the counters.
    fault_mode = 0;
    pulse_start(1'b0);
    check("restart_err_clr", err_a, 8'd0);
    check("restart_ff_clr", ff_a, 8'hFF);
    check("restart_done_low", done_a, 1'b0);
    wait_idle(1'b0, -1, cyc);
    check("restart_cycles", cyc, 17);
    check_results_a("restart", 1'b1, 8'd0, 8'hFF);

    // notq tied to q: every vector fails.
    fault_mode = 2;
    pulse_start(1'b0);
    wait_idle(1'b0, -1, cyc);
    check_results_a("notq_eq_q", 1'b0, 8'd16, 8'd0);

    // Set over reset: only vector 6 differs.
    fault_mode = 3;
    pulse_start(1'b0);
    wait_idle(1'b0, -1, cyc);
    check_results_a("set_prio", 1'b0, 8'd1, 8'd6);

    // start during RUN is ignored.
    fault_mode = 0;
    pulse_start(1'b0);
    wait_idle(1'b0, 4, cyc);
    check("run_start_ignored", cyc, 17);
    check_results_a("run_start", 1'b1, 8'd0, 8'hFF);

    // Reset abort at run cycle 5 with errors already counted.
    fault_mode = 1;
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    check("abort_pre_err", err_a, 8'd2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_err", err_a, 8'd0);
    check("abort_ff", ff_a, 8'hFF);
    check("abort_stim_reset", stim_reset_a, 1'b1);
    @(negedge clk);
    check("abort_stays_idle", busy_a, 1'b0);
    fault_mode = 0;
    pulse_start(1'b0);
    wait_idle(1'b0, -1, cyc);
    check("after_abort_cycles", cyc, 17);
    check_results_a("after_abort", 1'b1, 8'd0, 8'hFF);

    // Three-vector instance: table vectors 0..2 only.
    check("b_idle_done", done_b, 1'b0);
    pulse_start(1'b1);
    wait_idle(1'b1, -1, cyc);
    check("b_busy_cycles", cyc, 4);
    check("b_done", done_b, 1'b1);
    check("b_pass", pass_b, 1'b1);
    check("b_err", err_b, 8'd0);
    check("b_ff", ff_b, 8'hFF);
    for (int k = 0; k < 3; k++)
      check($sformatf("b_vec%0d", k), log_v[k], exp_vec[k]);
    check("b_drain_stim", log_v[3], 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
